// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and RAM-port signal bundle for mem_port_arbiter
//
// Purpose: groups the two requester handshakes and the single RAM port
// driven by mem_port_arbiter.
//
// Signals:
//   req_n, we_n, addr_n, wdata_n   requester n -> arbiter (n = 0, 1)
//   gnt_n, rvalid_n, rdata_n       arbiter -> requester n
//   mem_address, mem_write,        arbiter -> RAM (registered outputs)
//   mem_wren
//   mem_read                       RAM q -> arbiter (1-cycle read latency)
//
// Modports:
//   master  requester/RAM side (drives requests and mem_read)
//   slave   arbiter side
interface mem_port_arbiter_if #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
);
   logic                 req_0;
   logic                 we_0;
   logic [ADDR_SIZE-1:0] addr_0;
   logic [WORD_SIZE-1:0] wdata_0;
   logic                 gnt_0;
   logic                 rvalid_0;
   logic [WORD_SIZE-1:0] rdata_0;

   logic                 req_1;
   logic                 we_1;
   logic [ADDR_SIZE-1:0] addr_1;
   logic [WORD_SIZE-1:0] wdata_1;
   logic                 gnt_1;
   logic                 rvalid_1;
   logic [WORD_SIZE-1:0] rdata_1;

   logic [ADDR_SIZE-1:0] mem_address;
   logic [WORD_SIZE-1:0] mem_write;
   logic                 mem_wren;
   logic [WORD_SIZE-1:0] mem_read;

   modport master (
      output req_0, we_0, addr_0, wdata_0,
      input  gnt_0, rvalid_0, rdata_0,
      output req_1, we_1, addr_1, wdata_1,
      input  gnt_1, rvalid_1, rdata_1,
      input  mem_address, mem_write, mem_wren,
      output mem_read
   );

   modport slave (
      input  req_0, we_0, addr_0, wdata_0,
      output gnt_0, rvalid_0, rdata_0,
      input  req_1, we_1, addr_1, wdata_1,
      output gnt_1, rvalid_1, rdata_1,
      output mem_address, mem_write, mem_wren,
      input  mem_read
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester round-robin arbiter for one RAM port
//
// Purpose: shares a single RAM port (registered inputs, 1-cycle read
// latency) between two requesters, issuing at most one access per cycle.
// The winner's address/data/write-enable and its grant pulse are registered,
// so they appear together in the issue cycle; read data returns one cycle
// later, steered to the requester that issued it.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high reset
//   bus     mem_port_arbiter_if.slave (requesters 0/1 and RAM port)
module mem_port_arbiter #(
   parameter int ADDR_SIZE = 18,
   parameter int WORD_SIZE = 18
) (
   input  logic                  clock,
   input  logic                  reset,
   mem_port_arbiter_if.slave     bus
);

   logic                 win_0;
   logic                 win_1;
   logic                 win_we;
   logic [ADDR_SIZE-1:0] win_addr;
   logic [WORD_SIZE-1:0] win_wdata;

   // 1 when requester 1 has priority on the next tie (0 granted most recently)
   logic                 prio_1;

   logic                 gnt_0_q;
   logic                 gnt_1_q;
   logic                 rvalid_0_q;
   logic                 rvalid_1_q;
   logic                 wren_q;
   logic [ADDR_SIZE-1:0] address_q;
   logic [WORD_SIZE-1:0] write_q;

   // winner selection: a lone requester always wins; a tie goes to prio_1
   always_comb begin
      win_0     = bus.req_0 & (~bus.req_1 | ~prio_1);
      win_1     = bus.req_1 & ~win_0;
      win_we    = 1'b0;
      win_addr  = address_q;
      win_wdata = write_q;
      if (win_0) begin
         win_we    = bus.we_0;
         win_addr  = bus.addr_0;
         win_wdata = bus.wdata_0;
      end else if (win_1) begin
         win_we    = bus.we_1;
         win_addr  = bus.addr_1;
         win_wdata = bus.wdata_1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prio_1     <= 1'b0;
         gnt_0_q    <= 1'b0;
         gnt_1_q    <= 1'b0;
         rvalid_0_q <= 1'b0;
         rvalid_1_q <= 1'b0;
         wren_q     <= 1'b0;
         address_q  <= '0;
         write_q    <= '0;
      end else begin
         gnt_0_q   <= win_0;
         gnt_1_q   <= win_1;
         wren_q    <= win_we;
         // with no winner win_addr/win_wdata are the held values
         address_q <= win_addr;
         write_q   <= win_wdata;
         if (win_0 | win_1) begin
            prio_1 <= win_0;
         end
         // the grant register is the owner tag of the access now at the RAM;
         // a read issued this cycle returns next cycle to the same owner
         rvalid_0_q <= gnt_0_q & ~wren_q;
         rvalid_1_q <= gnt_1_q & ~wren_q;
      end
   end

   assign bus.gnt_0       = gnt_0_q;
   assign bus.gnt_1       = gnt_1_q;
   assign bus.rvalid_0    = rvalid_0_q;
   assign bus.rvalid_1    = rvalid_1_q;
   assign bus.rdata_0     = rvalid_0_q ? bus.mem_read : '0;
   assign bus.rdata_1     = rvalid_1_q ? bus.mem_read : '0;
   assign bus.mem_address = address_q;
   assign bus.mem_write   = write_q;
   assign bus.mem_wren    = wren_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int AW = 18;
   localparam int DW = 18;

   logic clock = 1'b0;
   logic reset;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus ();

   mem_port_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   // RAM model: registered inputs, q valid the cycle after the address edge.
   // Unwritten words hold a fixed pattern; written words are remembered.
   logic [255:0]  wr_valid = '0;
   logic [DW-1:0] wr_data [256];

   function automatic logic [DW-1:0] pattern_word(int a);
      if (a == 'h10) return 18'h2ABCD;
      return 18'(a * 1031 + 7);
   endfunction

   always @(posedge clock) begin
      if (bus.mem_wren) begin
         wr_valid[bus.mem_address[7:0]] <= 1'b1;
         wr_data[bus.mem_address[7:0]]  <= bus.mem_write;
      end
      bus.mem_read <= wr_valid[bus.mem_address[7:0]] ? wr_data[bus.mem_address[7:0]]
                                                      : pattern_word(int'(bus.mem_address[7:0]));
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".gnt_0"},    32'(bus.gnt_0), 0);
      check({tag, ".gnt_1"},    32'(bus.gnt_1), 0);
      check({tag, ".rvalid_0"}, 32'(bus.rvalid_0), 0);
      check({tag, ".rvalid_1"}, 32'(bus.rvalid_1), 0);
      check({tag, ".wren"},     32'(bus.mem_wren), 0);
      check({tag, ".address"},  32'(bus.mem_address), 0);
      check({tag, ".write"},    32'(bus.mem_write), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset       = 1'b1;
      bus.req_0   = 1'b1;
      bus.we_0    = 1'b1;
      bus.addr_0  = 18'h12345;
      bus.wdata_0 = 18'h15555;
      bus.req_1   = 1'b0;
      bus.we_1    = 1'b0;
      bus.addr_1  = '0;
      bus.wdata_1 = '0;

      // reset forces every output low even with a write request pending
      tick();
      tick();
      check_idle_outputs("reset");

      // single read of 0x10
      bus.we_0   = 1'b0;
      bus.addr_0 = 18'h00010;
      reset      = 1'b0;
      tick();
      check("rd.gnt_0",   32'(bus.gnt_0), 1);
      check("rd.gnt_1",   32'(bus.gnt_1), 0);
      check("rd.address", 32'(bus.mem_address), 'h10);
      check("rd.wren",    32'(bus.mem_wren), 0);
      check("rd.rvalid0_early", 32'(bus.rvalid_0), 0);
      bus.req_0 = 1'b0;
      tick();
      check("rd.rvalid_0", 32'(bus.rvalid_0), 1);
      check("rd.rdata_0",  32'(bus.rdata_0), 'h2ABCD);
      check("rd.rvalid_1", 32'(bus.rvalid_1), 0);
      check("rd.gnt_0_off", 32'(bus.gnt_0), 0);
      tick();
      check("rd.rvalid_0_off", 32'(bus.rvalid_0), 0);

      // contention from reset release: grants alternate 0,1,0,1
      reset      = 1'b1;
      bus.req_0  = 1'b1;
      bus.we_0   = 1'b0;
      bus.addr_0 = 18'h00020;
      bus.req_1  = 1'b1;
      bus.we_1   = 1'b0;
      bus.addr_1 = 18'h00030;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         tick();
         check($sformatf("cont%0d.gnt_0", k), 32'(bus.gnt_0), (k <= 4 && k % 2 == 1) ? 1 : 0);
         check($sformatf("cont%0d.gnt_1", k), 32'(bus.gnt_1), (k <= 4 && k % 2 == 0) ? 1 : 0);
         check($sformatf("cont%0d.both", k), 32'(bus.gnt_0 & bus.gnt_1), 0);
         check($sformatf("cont%0d.rvalid_0", k), 32'(bus.rvalid_0), (k % 2 == 0) ? 1 : 0);
         check($sformatf("cont%0d.rvalid_1", k), 32'(bus.rvalid_1), (k >= 3 && k % 2 == 1) ? 1 : 0);
         if (k % 2 == 0)
            check($sformatf("cont%0d.rdata_0", k), 32'(bus.rdata_0), 32'(pattern_word('h20)));
         if (k >= 3 && k % 2 == 1)
            check($sformatf("cont%0d.rdata_1", k), 32'(bus.rdata_1), 32'(pattern_word('h30)));
         if (k == 4) begin
            bus.req_0 = 1'b0;
            bus.req_1 = 1'b0;
         end
      end

      // requester 1: write 0x3FFFF to 0x5, then read it back-to-back
      bus.req_1   = 1'b1;
      bus.we_1    = 1'b1;
      bus.addr_1  = 18'h00005;
      bus.wdata_1 = 18'h3FFFF;
      tick();
      check("wr.gnt_1",   32'(bus.gnt_1), 1);
      check("wr.wren",    32'(bus.mem_wren), 1);
      check("wr.address", 32'(bus.mem_address), 5);
      check("wr.write",   32'(bus.mem_write), 'h3FFFF);
      bus.we_1 = 1'b0;
      tick();
      check("wr_rd.gnt_1",  32'(bus.gnt_1), 1);
      check("wr_rd.wren",   32'(bus.mem_wren), 0);
      check("wr_rd.no_rvalid", 32'(bus.rvalid_1), 0);
      bus.req_1 = 1'b0;
      tick();
      check("wr_rd.rvalid_1", 32'(bus.rvalid_1), 1);
      check("wr_rd.rdata_1",  32'(bus.rdata_1), 'h3FFFF);
      check("wr_rd.gnt_idle", 32'(bus.gnt_1), 0);
      check("wr_rd.wren_idle", 32'(bus.mem_wren), 0);
      tick();
      check("idle.rvalid_1", 32'(bus.rvalid_1), 0);
      check("idle.address_hold", 32'(bus.mem_address), 5);
      check("idle.write_hold",   32'(bus.mem_write), 'h3FFFF);

      // streaming: 8 reads from requester 0 at 0x40..0x47
      bus.req_0  = 1'b1;
      bus.we_0   = 1'b0;
      bus.addr_0 = 18'h00040;
      for (int k = 1; k <= 9; k++) begin
         tick();
         check($sformatf("strm%0d.gnt_0", k), 32'(bus.gnt_0), (k <= 8) ? 1 : 0);
         if (k <= 8)
            check($sformatf("strm%0d.address", k), 32'(bus.mem_address), 'h40 + k - 1);
         check($sformatf("strm%0d.rvalid_0", k), 32'(bus.rvalid_0), (k >= 2) ? 1 : 0);
         if (k >= 2)
            check($sformatf("strm%0d.rdata_0", k), 32'(bus.rdata_0), 32'(pattern_word('h40 + k - 2)));
         if (k < 8) bus.addr_0 = 18'(32'h40 + k);
         else       bus.req_0 = 1'b0;
      end
      tick();
      check("strm.rvalid_end", 32'(bus.rvalid_0), 0);

      // full-width address and data pass through unmodified
      bus.req_1   = 1'b1;
      bus.we_1    = 1'b1;
      bus.addr_1  = 18'h3FFFF;
      bus.wdata_1 = 18'h2AAAA;
      tick();
      check("wide.address", 32'(bus.mem_address), 'h3FFFF);
      check("wide.write",   32'(bus.mem_write), 'h2AAAA);
      check("wide.wren",    32'(bus.mem_wren), 1);
      bus.req_1 = 1'b0;
      tick();
      check("wide.wren_off", 32'(bus.mem_wren), 0);
      check("wide.no_rvalid", 32'(bus.rvalid_1), 0);

      // reset asserted in the issue cycle of a read discards its return
      bus.req_0  = 1'b1;
      bus.we_0   = 1'b0;
      bus.addr_0 = 18'h00010;
      tick();
      check("rst_mid.gnt_0", 32'(bus.gnt_0), 1);
      reset     = 1'b1;
      bus.req_0 = 1'b0;
      tick();
      check_idle_outputs("rst_mid.a");
      tick();
      check_idle_outputs("rst_mid.b");
      // requester 0 was granted last, yet the reset pointer favours it again
      reset     = 1'b0;
      bus.req_0 = 1'b1;
      bus.req_1 = 1'b1;
      bus.we_1  = 1'b0;
      bus.addr_1 = 18'h00030;
      tick();
      check("rst_tie.gnt_0", 32'(bus.gnt_0), 1);
      check("rst_tie.gnt_1", 32'(bus.gnt_1), 0);
      check("rst_tie.rvalid_0", 32'(bus.rvalid_0), 0);
      bus.req_0 = 1'b0;
      bus.req_1 = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
